// File: rtl/meas_sequencer.sv
// meas_sequencer
//
// Runs one measurement cycle over NUM_MODES modes.
//
// For each mode the sequencer does the following:
//   1. Loads the range/key word into the register over SPI.
//   2. Enables the sine generator.
//   3. Measures the current channel, then the MN channel.
//   4. Pushes both ADC words of each measurement into the FIFO.
//
// Every measurement waits SETTLE_PERIODS generator periods after a mux
// change before the ADC is started.
//
// Ports
//   clk, rst              clock, synchronous active-low reset
//   enable                run request; deasserting it aborts at once
//   continuous            rearm at mode 0 after the last mode
//   gen_new_period        one-cycle strobe at each generator period start
//   diap                  range code placed in the upper register bits
//   reg_start/reg_data    SPI register load request and word {diap, key}
//   reg_done              SPI completion strobe
//   cs_sel                chip select: 3=none, 2=register, 1=DAC
//   gen_enable            sine generator enable
//   mux_chn               analog mux: 0=none, 1=MN, 2=current
//   adc_start             ADC conversion-cycle start pulse
//   adc_complete          ADC done strobe; adc_data_1/2 valid with it
//   fifo_full/fifo_wr_en  FIFO back-pressure and write strobe
//   fifo_data             FIFO write data
//   mode_idx              current mode index
//   busy                  high whenever the FSM is out of IDLE
//   cycle_done            pulse after the last mode has completed
//   state_dbg             encoded FSM state, for observation only
//
// Every output comes straight from a flop. The combinational process
// computes the next value of each register, so each output already holds
// its value for a state during the first cycle of that state.
//
// FIFO write timing: a write is decided in WR1/WR2 from fifo_full in that
// cycle. The registered fifo_wr_en strobe then appears in the following
// cycle.
module meas_sequencer #(
    parameter int NUM_MODES      = 5,
    parameter int KEY_WIDTH      = 5,
    parameter int DIAP_WIDTH     = 3,   // KEY_WIDTH + DIAP_WIDTH must be 8
    parameter int ADC_WIDTH      = 24,
    parameter int SETTLE_PERIODS = 2,
    parameter logic [NUM_MODES*KEY_WIDTH-1:0] KEYS_TABLE =
        {5'd5, 5'd4, 5'd3, 5'd2, 5'd1}
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  continuous,
    input  logic                  gen_new_period,
    input  logic [DIAP_WIDTH-1:0] diap,
    output logic                  reg_start,
    output logic [7:0]            reg_data,
    input  logic                  reg_done,
    output logic [1:0]            cs_sel,
    output logic                  gen_enable,
    output logic [2:0]            mux_chn,
    output logic                  adc_start,
    input  logic                  adc_complete,
    input  logic [ADC_WIDTH-1:0]  adc_data_1,
    input  logic [ADC_WIDTH-1:0]  adc_data_2,
    input  logic                  fifo_full,
    output logic                  fifo_wr_en,
    output logic [ADC_WIDTH-1:0]  fifo_data,
    output logic [2:0]            mode_idx,
    output logic                  busy,
    output logic                  cycle_done,
    output logic [3:0]            state_dbg
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_WAIT_SYNC = 4'd1,
        S_LOAD_REG  = 4'd2,
        S_WAIT_REG  = 4'd3,
        S_GEN_ON    = 4'd4,
        S_SETTLE    = 4'd5,
        S_START     = 4'd6,
        S_WAIT_ADC  = 4'd7,
        S_WR1       = 4'd8,
        S_WR2       = 4'd9,
        S_GEN_OFF   = 4'd10,
        S_NEXT      = 4'd11
    } state_t;

    localparam logic [1:0] CS_NONE = 2'd3;
    localparam logic [1:0] CS_REG  = 2'd2;
    localparam logic [1:0] CS_DAC  = 2'd1;
    localparam logic [2:0] MUX_OFF = 3'd0;
    localparam logic [2:0] MUX_MN  = 3'd1;
    localparam logic [2:0] MUX_CUR = 3'd2;
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_PERIODS);

    state_t                 state, state_n;
    logic                   phase, phase_n;        // 0 = current, 1 = MN
    logic [3:0]             settle_cnt, settle_cnt_n;
    logic [ADC_WIDTH-1:0]   cap_1, cap_1_n, cap_2, cap_2_n;
    logic [2:0]             mode_n;
    logic                   reg_start_n, adc_start_n, fifo_wr_en_n, cycle_done_n;
    logic [7:0]             reg_data_n;
    logic [1:0]             cs_sel_n;
    logic                   gen_enable_n;
    logic [2:0]             mux_chn_n;
    logic [ADC_WIDTH-1:0]   fifo_data_n;

    function automatic logic [KEY_WIDTH-1:0] key_of(input logic [2:0] m);
        return KEYS_TABLE[int'(m)*KEY_WIDTH +: KEY_WIDTH];
    endfunction

    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            phase      <= 1'b0;
            settle_cnt <= 4'd0;
            cap_1      <= '0;
            cap_2      <= '0;
            mode_idx   <= 3'd0;
            reg_start  <= 1'b0;
            reg_data   <= 8'd0;
            cs_sel     <= CS_NONE;
            gen_enable <= 1'b0;
            mux_chn    <= MUX_OFF;
            adc_start  <= 1'b0;
            fifo_wr_en <= 1'b0;
            fifo_data  <= '0;
            busy       <= 1'b0;
            cycle_done <= 1'b0;
        end else begin
            state      <= state_n;
            phase      <= phase_n;
            settle_cnt <= settle_cnt_n;
            cap_1      <= cap_1_n;
            cap_2      <= cap_2_n;
            mode_idx   <= mode_n;
            reg_start  <= reg_start_n;
            reg_data   <= reg_data_n;
            cs_sel     <= cs_sel_n;
            gen_enable <= gen_enable_n;
            mux_chn    <= mux_chn_n;
            adc_start  <= adc_start_n;
            fifo_wr_en <= fifo_wr_en_n;
            fifo_data  <= fifo_data_n;
            busy       <= (state_n != S_IDLE);
            cycle_done <= cycle_done_n;
        end
    end

    always_comb begin
        // Levels hold their value; pulses default low.
        state_n      = state;
        phase_n      = phase;
        settle_cnt_n = settle_cnt;
        cap_1_n      = cap_1;
        cap_2_n      = cap_2;
        mode_n       = mode_idx;
        reg_data_n   = reg_data;
        cs_sel_n     = cs_sel;
        gen_enable_n = gen_enable;
        mux_chn_n    = mux_chn;
        fifo_data_n  = fifo_data;
        reg_start_n  = 1'b0;
        adc_start_n  = 1'b0;
        fifo_wr_en_n = 1'b0;
        cycle_done_n = 1'b0;

        if (state != S_IDLE && !enable) begin
            // Abort wins over any strobe arriving in the same cycle. The
            // pulse defaults above also drop any write still pending.
            state_n      = S_IDLE;
            phase_n      = 1'b0;
            mode_n       = 3'd0;
            cs_sel_n     = CS_NONE;
            gen_enable_n = 1'b0;
            mux_chn_n    = MUX_OFF;
        end else begin
            case (state)
                S_IDLE: begin
                    if (enable) state_n = S_WAIT_SYNC;
                end
                S_WAIT_SYNC: begin
                    if (gen_new_period) begin
                        state_n     = S_LOAD_REG;
                        reg_start_n = 1'b1;
                        cs_sel_n    = CS_REG;
                        reg_data_n  = {diap, key_of(mode_idx)};
                    end
                end
                S_LOAD_REG: state_n = S_WAIT_REG;
                S_WAIT_REG: begin
                    if (reg_done) begin
                        state_n      = S_GEN_ON;
                        cs_sel_n     = CS_DAC;
                        gen_enable_n = 1'b1;
                        mux_chn_n    = MUX_CUR;
                        phase_n      = 1'b0;
                        settle_cnt_n = SETTLE_LOAD;
                    end
                end
                S_GEN_ON: state_n = S_SETTLE;
                S_SETTLE: begin
                    if (gen_new_period) begin
                        if (settle_cnt == 4'd0) begin
                            state_n     = S_START;
                            adc_start_n = 1'b1;
                        end else begin
                            settle_cnt_n = settle_cnt - 4'd1;
                        end
                    end
                end
                S_START: state_n = S_WAIT_ADC;
                S_WAIT_ADC: begin
                    if (adc_complete) begin
                        cap_1_n = adc_data_1;
                        cap_2_n = adc_data_2;
                        state_n = S_WR1;
                    end
                end
                S_WR1: begin
                    if (!fifo_full) begin
                        fifo_wr_en_n = 1'b1;
                        fifo_data_n  = cap_1;
                        state_n      = S_WR2;
                    end
                end
                S_WR2: begin
                    if (!fifo_full) begin
                        fifo_wr_en_n = 1'b1;
                        fifo_data_n  = cap_2;
                        if (!phase) begin
                            phase_n      = 1'b1;
                            mux_chn_n    = MUX_MN;
                            settle_cnt_n = SETTLE_LOAD;
                            state_n      = S_SETTLE;
                        end else begin
                            state_n = S_GEN_OFF;
                        end
                    end
                end
                S_GEN_OFF: begin
                    gen_enable_n = 1'b0;
                    cs_sel_n     = CS_NONE;
                    mux_chn_n    = MUX_OFF;
                    state_n      = S_NEXT;
                end
                S_NEXT: begin
                    if (int'(mode_idx) < NUM_MODES - 1) begin
                        mode_n      = mode_idx + 3'd1;
                        state_n     = S_LOAD_REG;
                        reg_start_n = 1'b1;
                        cs_sel_n    = CS_REG;
                        reg_data_n  = {diap, key_of(mode_n)};
                    end else begin
                        cycle_done_n = 1'b1;
                        mode_n       = 3'd0;
                        state_n      = continuous ? S_WAIT_SYNC : S_IDLE;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_meas_sequencer.sv
// Bench for meas_sequencer.
// Instance A: default parameters, continuous tied low.
// Instance B: NUM_MODES=2, keys {7,6}, SETTLE_PERIODS=0.
// Both instances share all stimulus inputs except enable. The idle
// instance ignores the shared strobes, and sel_b picks whose outputs are
// observed. Outputs are sampled and inputs driven on the falling edge.
`timescale 1ns/1ps
module tb_meas_sequencer;
  localparam int AW = 24;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en_a, en_b, continuous, gnp, reg_done, adc_complete, fifo_full, sel_b;
  logic [2:0] diap;
  logic [AW-1:0] adc_d1, adc_d2;

  logic a_reg_start, a_gen_enable, a_adc_start, a_fifo_wr_en, a_busy, a_cycle_done;
  logic [7:0] a_reg_data;
  logic [1:0] a_cs_sel;
  logic [2:0] a_mux_chn, a_mode_idx;
  logic [AW-1:0] a_fifo_data;
  logic [3:0] a_state;

  logic b_reg_start, b_gen_enable, b_adc_start, b_fifo_wr_en, b_busy, b_cycle_done;
  logic [7:0] b_reg_data;
  logic [1:0] b_cs_sel;
  logic [2:0] b_mux_chn, b_mode_idx;
  logic [AW-1:0] b_fifo_data;
  logic [3:0] b_state;

  meas_sequencer dut_a (
    .clk(clk), .rst(rst), .enable(en_a), .continuous(1'b0), .gen_new_period(gnp),
    .diap(diap), .reg_start(a_reg_start), .reg_data(a_reg_data), .reg_done(reg_done),
    .cs_sel(a_cs_sel), .gen_enable(a_gen_enable), .mux_chn(a_mux_chn),
    .adc_start(a_adc_start), .adc_complete(adc_complete), .adc_data_1(adc_d1),
    .adc_data_2(adc_d2), .fifo_full(fifo_full), .fifo_wr_en(a_fifo_wr_en),
    .fifo_data(a_fifo_data), .mode_idx(a_mode_idx), .busy(a_busy),
    .cycle_done(a_cycle_done), .state_dbg(a_state)
  );

  meas_sequencer #(
    .NUM_MODES(2), .SETTLE_PERIODS(0), .KEYS_TABLE({5'd7, 5'd6})
  ) dut_b (
    .clk(clk), .rst(rst), .enable(en_b), .continuous(continuous), .gen_new_period(gnp),
    .diap(diap), .reg_start(b_reg_start), .reg_data(b_reg_data), .reg_done(reg_done),
    .cs_sel(b_cs_sel), .gen_enable(b_gen_enable), .mux_chn(b_mux_chn),
    .adc_start(b_adc_start), .adc_complete(adc_complete), .adc_data_1(adc_d1),
    .adc_data_2(adc_d2), .fifo_full(fifo_full), .fifo_wr_en(b_fifo_wr_en),
    .fifo_data(b_fifo_data), .mode_idx(b_mode_idx), .busy(b_busy),
    .cycle_done(b_cycle_done), .state_dbg(b_state)
  );

  logic obs_reg_start, obs_gen_enable, obs_adc_start, obs_fifo_wr_en, obs_busy, obs_cycle_done;
  logic [7:0] obs_reg_data;
  logic [1:0] obs_cs_sel;
  logic [2:0] obs_mux_chn, obs_mode_idx;
  logic [AW-1:0] obs_fifo_data;
  logic [3:0] obs_state;

  assign obs_reg_start  = sel_b ? b_reg_start  : a_reg_start;
  assign obs_gen_enable = sel_b ? b_gen_enable : a_gen_enable;
  assign obs_adc_start  = sel_b ? b_adc_start  : a_adc_start;
  assign obs_fifo_wr_en = sel_b ? b_fifo_wr_en : a_fifo_wr_en;
  assign obs_busy       = sel_b ? b_busy       : a_busy;
  assign obs_cycle_done = sel_b ? b_cycle_done : a_cycle_done;
  assign obs_reg_data   = sel_b ? b_reg_data   : a_reg_data;
  assign obs_cs_sel     = sel_b ? b_cs_sel     : a_cs_sel;
  assign obs_mux_chn    = sel_b ? b_mux_chn    : a_mux_chn;
  assign obs_mode_idx   = sel_b ? b_mode_idx   : a_mode_idx;
  assign obs_fifo_data  = sel_b ? b_fifo_data  : a_fifo_data;
  assign obs_state      = sel_b ? b_state      : a_state;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [AW-1:0] exp_q[$];
  logic [7:0] exp_reg[$];

  // ---------------- driver / responder ----------------
  // Acts as the generator, the SPI slave, the ADC and the FIFO for the
  // observed instance. It returns when one of these happens:
  //   - cycle_done is seen,
  //   - the abort has been driven,
  //   - reset has been driven in SETTLE.
  // Generator periods are counted from each observed mux change. No period
  // strobe is issued on the cycle where a change is first seen.
  task automatic run_seq(input int exp_gnp, input int stall_cycles, input bit abort_adc,
                         input bit rst_settle, output int n_done, output int n_wr);
    int gcnt = 0;
    int gtimer = 0;
    int stall_left = 0;
    int k = 0;
    bit stalling = 0;
    bit reg_pend = 0;
    bit adc_pend = 0;
    bit stop = 0;
    bit changed;
    logic [2:0] prev_mux;
    logic [AW-1:0] exp_w;
    logic [7:0] exp_r;
    n_done = 0;
    n_wr = 0;
    prev_mux = obs_mux_chn;
    for (int c = 0; c < 4000 && !stop; c++) begin
      @(negedge clk);
      gnp = 1'b0;
      reg_done = 1'b0;
      adc_complete = 1'b0;
      if (stalling) begin
        checks++;
        if (obs_fifo_wr_en !== 1'b0 || obs_state !== 4'd8) begin
          errors++;
          $display("FAIL stall_hold wr_en=%0b state=%0d, required wr_en=0 state=8",
                   obs_fifo_wr_en, obs_state);
        end
        stall_left--;
        if (stall_left == 0) begin
          stalling = 0;
          fifo_full = 1'b0;
        end
      end
      if (reg_pend) begin
        reg_done = 1'b1;
        reg_pend = 0;
      end
      if (adc_pend) begin
        adc_pend = 0;
        adc_d1 = 24'h100000 + 24'(k);
        adc_d2 = 24'h200000 + 24'(k);
        k++;
        adc_complete = 1'b1;
        if (abort_adc) begin
          en_a = 1'b0;
          en_b = 1'b0;
          stop = 1;
        end else begin
          exp_q.push_back(adc_d1);
          exp_q.push_back(adc_d2);
          if (stall_cycles > 0 && k == 1) begin
            fifo_full = 1'b1;
            stalling = 1;
            stall_left = stall_cycles;
          end
        end
      end
      if (obs_fifo_wr_en === 1'b1) begin
        n_wr++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL fifo_write unexpected data=%h, required no write", obs_fifo_data);
        end else begin
          exp_w = exp_q.pop_front();
          if (obs_fifo_data !== exp_w) begin
            errors++;
            $display("FAIL fifo_data got %h, required %h", obs_fifo_data, exp_w);
          end
        end
      end
      if (obs_reg_start === 1'b1) begin
        checks++;
        if (exp_reg.size() == 0) begin
          errors++;
          $display("FAIL reg_start unexpected reg_data=%h", obs_reg_data);
        end else begin
          exp_r = exp_reg.pop_front();
          if (obs_reg_data !== exp_r) begin
            errors++;
            $display("FAIL reg_data got %h, required %h", obs_reg_data, exp_r);
          end
        end
        reg_pend = 1;
      end
      if (obs_adc_start === 1'b1) begin
        checks++;
        if (gcnt != exp_gnp) begin
          errors++;
          $display("FAIL settle_periods adc_start after %0d periods, required %0d", gcnt, exp_gnp);
        end
        adc_pend = 1;
      end
      if (obs_cycle_done === 1'b1) begin
        n_done++;
        stop = 1;
      end
      if (rst_settle && obs_state === 4'd5) begin
        rst = 1'b0;
        stop = 1;
      end
      changed = (obs_mux_chn !== prev_mux);
      prev_mux = obs_mux_chn;
      if (changed) gcnt = 0;
      gtimer++;
      if (!stop && !changed && gtimer >= 6) begin
        gnp = 1'b1;
        gtimer = 0;
        gcnt++;
      end
    end
    if (!stop) begin
      checks++;
      errors++;
      $display("FAIL run_timeout state=%0d, required progress within 4000 cycles", obs_state);
      gnp = 1'b0;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks += 12;
    if (obs_reg_start !== 1'b0)  begin errors++; $display("FAIL rst_reg_start got %b, required 0", obs_reg_start); end
    if (obs_reg_data !== 8'h00)  begin errors++; $display("FAIL rst_reg_data got %h, required 00", obs_reg_data); end
    if (obs_cs_sel !== 2'd3)     begin errors++; $display("FAIL rst_cs_sel got %0d, required 3", obs_cs_sel); end
    if (obs_gen_enable !== 1'b0) begin errors++; $display("FAIL rst_gen_enable got %b, required 0", obs_gen_enable); end
    if (obs_mux_chn !== 3'd0)    begin errors++; $display("FAIL rst_mux_chn got %0d, required 0", obs_mux_chn); end
    if (obs_adc_start !== 1'b0)  begin errors++; $display("FAIL rst_adc_start got %b, required 0", obs_adc_start); end
    if (obs_fifo_wr_en !== 1'b0) begin errors++; $display("FAIL rst_fifo_wr_en got %b, required 0", obs_fifo_wr_en); end
    if (obs_fifo_data !== 24'h0) begin errors++; $display("FAIL rst_fifo_data got %h, required 0", obs_fifo_data); end
    if (obs_mode_idx !== 3'd0)   begin errors++; $display("FAIL rst_mode_idx got %0d, required 0", obs_mode_idx); end
    if (obs_busy !== 1'b0)       begin errors++; $display("FAIL rst_busy got %b, required 0", obs_busy); end
    if (obs_cycle_done !== 1'b0) begin errors++; $display("FAIL rst_cycle_done got %b, required 0", obs_cycle_done); end
    if (obs_state !== 4'd0)      begin errors++; $display("FAIL rst_state got %0d, required 0", obs_state); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_cycle(input int stall_cycles);
    int nd, nw;
    sel_b = 1'b0;
    exp_q.delete();
    exp_reg = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
    en_a = 1'b1;
    run_seq(3, stall_cycles, 1'b0, 1'b0, nd, nw);
    en_a = 1'b0;
    checks += 6;
    if (nd != 1)              begin errors++; $display("FAIL cycle_done_count got %0d, required 1", nd); end
    if (nw != 20)             begin errors++; $display("FAIL fifo_write_count got %0d, required 20", nw); end
    if (exp_q.size() != 0)    begin errors++; $display("FAIL fifo_words_left got %0d, required 0", exp_q.size()); end
    if (exp_reg.size() != 0)  begin errors++; $display("FAIL reg_loads_left got %0d, required 0", exp_reg.size()); end
    if (obs_state !== 4'd0 || obs_busy !== 1'b0)
      begin errors++; $display("FAIL end_idle state=%0d busy=%b, required 0 0", obs_state, obs_busy); end
    if (obs_gen_enable !== 1'b0 || obs_cs_sel !== 2'd3 || obs_mode_idx !== 3'd0)
      begin errors++; $display("FAIL end_outputs gen=%b cs=%0d mode=%0d, required 0 3 0",
                               obs_gen_enable, obs_cs_sel, obs_mode_idx); end
    @(negedge clk);
    checks++;
    if (obs_cycle_done !== 1'b0) begin errors++; $display("FAIL cycle_done_width got %b, required 0", obs_cycle_done); end
  endtask

  task automatic test_abort_in_wait_adc();
    int nd, nw;
    sel_b = 1'b0;
    exp_q.delete();
    exp_reg = '{8'h41};
    en_a = 1'b1;
    run_seq(3, 0, 1'b1, 1'b0, nd, nw);
    @(negedge clk);
    adc_complete = 1'b0;
    checks += 4;
    if (obs_gen_enable !== 1'b0 || obs_cs_sel !== 2'd3 || obs_mux_chn !== 3'd0)
      begin errors++; $display("FAIL abort_outputs gen=%b cs=%0d mux=%0d, required 0 3 0",
                               obs_gen_enable, obs_cs_sel, obs_mux_chn); end
    if (obs_state !== 4'd0 || obs_busy !== 1'b0 || obs_mode_idx !== 3'd0)
      begin errors++; $display("FAIL abort_idle state=%0d busy=%b mode=%0d, required 0 0 0",
                               obs_state, obs_busy, obs_mode_idx); end
    if (obs_fifo_wr_en !== 1'b0 || nw != 0)
      begin errors++; $display("FAIL abort_no_write wr_en=%b writes=%0d, required 0 0", obs_fifo_wr_en, nw); end
    repeat (4) @(negedge clk);
    if (obs_fifo_wr_en !== 1'b0 || obs_state !== 4'd0)
      begin errors++; $display("FAIL abort_stays_idle wr_en=%b state=%0d, required 0 0", obs_fifo_wr_en, obs_state); end
  endtask

  task automatic test_continuous();
    int nd, nw;
    sel_b = 1'b1;
    continuous = 1'b1;
    exp_q.delete();
    exp_reg = '{8'h46, 8'h47};
    en_b = 1'b1;
    run_seq(1, 0, 1'b0, 1'b0, nd, nw);
    checks += 3;
    if (nd != 1 || nw != 8)
      begin errors++; $display("FAIL cont_counts done=%0d writes=%0d, required 1 8", nd, nw); end
    if (obs_state !== 4'd1 || obs_busy !== 1'b1 || obs_mode_idx !== 3'd0)
      begin errors++; $display("FAIL cont_rearm state=%0d busy=%b mode=%0d, required 1 1 0",
                               obs_state, obs_busy, obs_mode_idx); end
    gnp = 1'b1;
    @(negedge clk);
    gnp = 1'b0;
    if (obs_reg_start !== 1'b1 || obs_reg_data !== 8'h46 || obs_cs_sel !== 2'd2 || obs_mode_idx !== 3'd0)
      begin errors++; $display("FAIL cont_restart start=%b data=%h cs=%0d mode=%0d, required 1 46 2 0",
                               obs_reg_start, obs_reg_data, obs_cs_sel, obs_mode_idx); end
    en_b = 1'b0;
    @(negedge clk);
    checks++;
    if (obs_state !== 4'd0 || obs_cs_sel !== 2'd3)
      begin errors++; $display("FAIL cont_abort state=%0d cs=%0d, required 0 3", obs_state, obs_cs_sel); end
    continuous = 1'b0;
    sel_b = 1'b0;
  endtask

  task automatic test_reset_in_settle();
    int nd, nw;
    sel_b = 1'b0;
    exp_q.delete();
    exp_reg = '{8'h41};
    en_a = 1'b1;
    run_seq(3, 0, 1'b0, 1'b1, nd, nw);
    @(negedge clk);
    checks += 3;
    if (obs_gen_enable !== 1'b0 || obs_cs_sel !== 2'd3 || obs_mux_chn !== 3'd0 || obs_reg_data !== 8'h00)
      begin errors++; $display("FAIL rst_settle_outputs gen=%b cs=%0d mux=%0d data=%h, required 0 3 0 00",
                               obs_gen_enable, obs_cs_sel, obs_mux_chn, obs_reg_data); end
    if (obs_state !== 4'd0 || obs_busy !== 1'b0 || obs_mode_idx !== 3'd0 || obs_fifo_data !== 24'h0)
      begin errors++; $display("FAIL rst_settle_state state=%0d busy=%b mode=%0d fdata=%h, required 0 0 0 0",
                               obs_state, obs_busy, obs_mode_idx, obs_fifo_data); end
    if (obs_reg_start !== 1'b0 || obs_adc_start !== 1'b0 || obs_fifo_wr_en !== 1'b0 || obs_cycle_done !== 1'b0)
      begin errors++; $display("FAIL rst_settle_pulses rs=%b as=%b we=%b cd=%b, required 0 0 0 0",
                               obs_reg_start, obs_adc_start, obs_fifo_wr_en, obs_cycle_done); end
    rst = 1'b1;
    en_a = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst = 1'b0; en_a = 1'b0; en_b = 1'b0; continuous = 1'b0; gnp = 1'b0;
    diap = 3'b010; reg_done = 1'b0; adc_complete = 1'b0; adc_d1 = '0; adc_d2 = '0;
    fifo_full = 1'b0; sel_b = 1'b0;
    test_reset();
    test_full_cycle(0);
    test_full_cycle(10);
    test_abort_in_wait_adc();
    test_continuous();
    test_reset_in_settle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
